// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Operand/result valid-ready bundle for serial_subtractor.
//            SERIAL_SUB_OVF_EN adds the signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    modport master (
        output in_valid, A, B, Bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, D, Bout
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, D, Bout
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial D = A - B - Bin, LSB first, one bit per clock.
//            Optional macro SERIAL_SUB_OVF_EN adds the signed overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_last = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_d;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic          r_bout;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic          w_a;
    logic          w_b;
    logic          w_d;
    logic          w_borrow_nxt;

    // Single full-subtractor cell working on the current LSBs.
    assign w_a          = r_a_sh[0];
    assign w_b          = r_b_sh[0];
    assign w_d          = w_a ^ w_b ^ r_borrow;
    assign w_borrow_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.A;
            r_b_sh   <= bus.B;
            r_borrow <= bus.Bin;
            r_cnt    <= '0;
        end else if (w_run) begin
            // Result bits enter at the MSB so bit 0 lands in place after N shifts.
            r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
            r_d      <= {w_d, r_d[N-1:1]};
            r_borrow <= w_borrow_nxt;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_bout <= w_borrow_nxt;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the final edge the cell is looking at the operand and result MSBs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (w_a != w_b) && (w_d != w_a);
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.D         = r_d;
    assign bus.Bout      = r_bout;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing D = A - B - Bin with one full-subtractor cell and a borrow flop, LSB first, one bit per clock. This is the subtracting counterpart to the team's parallel ripple-carry adder. It trades latency for area and is used where a full-width subtract path is too large. Both operands and results use valid/ready handshakes.

Parameters:
N, 8, operand/result width in bits; N >= 2
CW, $clog2(N), bit-counter width; derived, not overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  N  minuend, sampled on accept
B  input  N  subtrahend, sampled on accept
Bin  input  1  borrow-in, sampled on accept
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
D  output  N  difference A - B - Bin mod 2^N
Bout  output  1  final borrow-out; 1 iff A < B + Bin (unsigned)

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - state=IDLE; in_ready=1; out_valid=0; D=0; Bout=0.
  - Internal A/B shift registers, borrow flop and counter cleared.
- States:
  - IDLE: in_ready=1. Accept occurs on an edge with in_valid&in_ready. On accept: load A and B into shift registers, borrow=Bin, cnt=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge processes bit a=A_sh[0], b=B_sh[0]:
    - d = a^b^borrow
    - borrow_next = (~a&b) | (~(a^b)&borrow)
    - d is shifted into D from the MSB side (D shifts right); A_sh and B_sh shift right.
    - cnt increments. On the edge where cnt==N-1: go to DONE and Bout=borrow_next.
  - DONE: out_valid=1; D and Bout held stable. On an edge with out_ready=1, go to IDLE. out_valid drops and in_ready rises in the same cycle.
- Latency: out_valid rises exactly N clocks after the accept edge. Throughput is one operation per N+2 cycles minimum.
- in_valid while not in IDLE is ignored. No operand capture, no error.
- out_ready while not in DONE is ignored.
- Backpressure: out_ready held low keeps the block in DONE indefinitely with D/Bout constant.
- D is undefined-but-deterministic during RUN (partial shift). Consumers use it only when out_valid=1.
- D and Bout are held in IDLE until the next accept.
- Arithmetic is unsigned modulo 2^N. Bout equals the inverted carry of A + ~B + ~Bin.
- Reset asserted mid-RUN or in DONE aborts immediately to the reset state. The pending result is lost; no out_valid pulse.

Optional Feature:
SERIAL_SUB_OVF_EN:
- Defined: adds output port ovf (1 bit), reset 0. Captured on the final RUN edge as the signed two's-complement overflow: (a_msb != b_msb) && (d_msb != a_msb), using the MSB bits processed on that edge. ovf is valid and stable alongside out_valid and held like D.
- Undefined: no ovf port and no MSB-capture logic. Behaviour is otherwise identical.

Test Plan:
- N=8, accept A=100, B=37, Bin=0 -> out_valid exactly 8 clocks after accept; D=63, Bout=0; in_ready=0 throughout RUN.
- A=5, B=9, Bin=0 -> D=252, Bout=1. Then A=0, B=0, Bin=1 -> D=255, Bout=1. Then A=255, B=255, Bin=0 -> D=0, Bout=0.
- Backpressure: complete an op, hold out_ready=0 for 5 cycles with in_valid=1 and new operands -> D/out_valid stable, no new accept. Raise out_ready -> IDLE next cycle; the new operand pair is accepted only when in_ready=1.
- Reset mid-op: assert rst 3 cycles after accept (asynchronously, between edges) -> outputs return to reset values immediately. A subsequent op A=20, B=3 yields D=17 with full N-cycle latency.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 -> D=0x7F, Bout=0, ovf=1. A=0x7F, B=0xFF -> D=0x80, Bout=1, ovf=1. A=0x10, B=0x01 -> ovf=0.
- Randomised back-to-back ops (>=1000) with random out_ready stalls -> every D/Bout matches reference A-B-Bin; accepts equal completions.
